bk_adder_pipe: RTL and testbench
================================

// Module: bk_adder_pipe
// PURPOSE
//  Parametrised, pipelined Brent-Kung prefix adder/subtractor; next generation of the 16-bit combinational BK adder.
//  WIDTH-bit operands, add/sub mode, carry/borrow in, carry out and signed overflow, tag pass-through.
//  Valid/ready streaming interface at both ends; one operation per cycle, full back-pressure.
//  Used as the shared arithmetic unit in datapaths needing a fixed, registered latency.
// PARAMETERS
//  WIDTH   16  operand/sum width; power of two, 4..64
//  STAGES  3   pipeline latency in cycles; 1..log2(WIDTH)+1; registers split the prefix tree into balanced levels
//  TAG_W   4   width of sideband tag carried alongside each operation (>=1)
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       synchronous, active-low reset
//  in_valid   in   1       operation offered
//  in_ready   out  1       block accepts operation this cycle
//  in_a       in   WIDTH   operand A
//  in_b       in   WIDTH   operand B
//  in_cin     in   1       carry in (add) / borrow in (sub)
//  in_sub     in   1       0 = add, 1 = subtract
//  in_tag     in   TAG_W   sideband, returned unchanged
//  out_valid  out  1       result present
//  out_ready  in   1       downstream accepts result
//  out_sum    out  WIDTH   result
//  out_cout   out  1       carry out (sub: 1 = no borrow)
//  out_ovf    out  1       two's-complement signed overflow
//  out_tag    out  TAG_W   tag of this result
// BEHAVIOUR
//  Arithmetic (mod 2^WIDTH):
//   - add: {cout,sum} = a + b + cin
//   - sub: {cout,sum} = a + ~b + ~cin, i.e. a - b - cin; cout=0 means borrow
//   - ovf = (a[W-1] == b'[W-1]) && (sum[W-1] != a[W-1]); b' = b or ~b per mode
//   - p/g from (a, b'); BK up-sweep then down-sweep; carry-in folded at bit 0; sum_i = p_i ^ c_i
//  Pipeline:
//   - STAGES register slices, each with its own valid bit; transfer on in_valid&&in_ready
//   - slice k loads when empty or when slice k+1 loads/drains; last slice drains on out_ready
//   - in_ready = !valid[0] || slice 0 advancing; combinational path from out_ready allowed
//   - bubbles collapse: a stalled output does not block filling empty slices
//   - latency STAGES cycles with no stall: accepted at edge N -> out_valid high after edge N+STAGES-1
//   - throughput 1 op/cycle with out_ready held high; order strictly preserved
//   - out_* data stable while out_valid && !out_ready; no drop, no duplicate
//   - out_sum/out_cout/out_ovf/out_tag are don't-care when out_valid=0
//  Reset (rst_n=0 at a rising edge):
//   - all valid bits cleared; out_valid=0; out_sum=0, out_cout=0, out_ovf=0, out_tag=0
//   - in_ready=1 from first cycle after reset release
//   - reset mid-operation discards every in-flight op; no result emitted for them
//  Boundaries:
//   - simultaneous accept and drain when full: both occur, occupancy unchanged
//   - full pipeline with out_ready=0: in_ready=0 until a slot frees
//   - WIDTH=4: tree degenerates correctly; STAGES=1: single output register
// TESTING (WIDTH=16, STAGES=3, TAG_W=4)
//  - add 0xFFFF+0x0001 cin0 tag3 -> 3 cycles later sum 0x0000 cout1 ovf0 tag3
//  - add 0x7FFF+0x0001 cin0 -> sum 0x8000 cout0 ovf1; add 0x1234+0x4321 cin1 -> 0x5556 cout0 ovf0
//  - sub 0x0005-0x0007 cin0 -> 0xFFFE cout0 ovf0; sub 0x8000-0x0001 cin0 -> 0x7FFF cout1 ovf1
//  - 100 back-to-back random ops, out_ready=1 -> one result per cycle, in order, match golden model
//  - out_ready=0 for 10 cycles while streaming -> 3 ops held, in_ready=0, result 1 stable; release -> no loss/dup
//  - rst_n=0 for one cycle with 3 ops in flight -> out_valid=0 next cycle, out_sum=0, none of the 3 appear

Source files
------------

// File: rtl/bk_adder_pipe.sv
// Pipelined Brent-Kung prefix adder/subtractor with valid/ready flow control.
// The 2*log2(WIDTH)-1 prefix levels are spread evenly across STAGES register slices.
module bk_adder_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LOG  = $clog2(WIDTH);
    localparam int unsigned NLVL = 2 * LOG - 1;
    localparam int unsigned NMID = (STAGES > 1) ? STAGES - 1 : 1;

    typedef struct packed {
        logic [WIDTH-1:0] g;    // group generate; holds the prefix carry once the tree is done
        logic [WIDTH-1:0] p;    // group propagate
        logic [WIDTH-1:0] x;    // bitwise propagate, needed again for the sum
        logic             cin;
        logic             a_msb;
        logic             b_msb;
        logic [TAG_W-1:0] tag;
    } stage_t;

    // Levels 0..LOG-1 are the up-sweep, the remaining LOG-1 levels the down-sweep.
    function automatic logic [2*WIDTH-1:0] bk_level(input logic [WIDTH-1:0] g,
                                                    input logic [WIDTH-1:0] p,
                                                    input int unsigned      lvl);
        logic [WIDTH-1:0] m;
        logic [WIDTH-1:0] go;
        logic [WIDTH-1:0] po;
        int unsigned      span;
        logic             sel;
        m = '0;
        if (lvl < LOG) span = 32'd1 << lvl;
        else           span = 32'd1 << (2 * LOG - 2 - lvl);
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (lvl < LOG) sel = ((i + 1) % (2 * span) == 0);
            else           sel = ((i + 1) % (2 * span) == span) && (i >= 2 * span);
            if (sel) m = m | ({{(WIDTH-1){1'b0}}, 1'b1} << i);
        end
        go = g | (m & p & (g << span));
        po = (p & ~m) | (m & p & (p << span));
        return {go, po};
    endfunction

    logic [STAGES-1:0] r_vld;
    logic [STAGES-1:0] w_free;
    stage_t [STAGES-1:0] w_src;
    stage_t [NMID-1:0]   r_mid;
    stage_t              w_pg;
    logic [WIDTH-1:0]    w_b;
    logic                w_ci;
    logic [WIDTH-1:0]    r_sum;
    logic                r_cout;
    logic                r_ovf;
    logic [TAG_W-1:0]    r_tag;

    always_comb begin
        w_b        = in_sub ? ~in_b : in_b;
        w_ci       = in_sub ? ~in_cin : in_cin;
        w_pg       = '0;
        w_pg.x     = in_a ^ w_b;
        w_pg.p     = w_pg.x;
        w_pg.g     = in_a & w_b;
        w_pg.g[0]  = w_pg.g[0] | (w_pg.x[0] & w_ci);
        w_pg.cin   = w_ci;
        w_pg.a_msb = in_a[WIDTH-1];
        w_pg.b_msb = w_b[WIDTH-1];
        w_pg.tag   = in_tag;
    end

    assign w_src[0] = w_pg;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int unsigned LVL_LO = s * NLVL / STAGES;
        localparam int unsigned LVL_HI = (s + 1) * NLVL / STAGES;

        stage_t w_lvl;
        logic   w_vld_in;

        always_comb begin
            w_lvl = w_src[s];
            for (int unsigned l = LVL_LO; l < LVL_HI; l++) begin
                {w_lvl.g, w_lvl.p} = bk_level(w_lvl.g, w_lvl.p, l);
            end
        end

        // A slice may load if any slice at or beyond it is empty, or the output drains.
        assign w_free[s] = out_ready || !(&r_vld[STAGES-1:s]);

        if (s == 0) begin : g_head
            assign w_vld_in = in_valid;
        end else begin : g_body
            assign w_vld_in = r_vld[s-1];
        end

        always_ff @(posedge clk) begin
            if (!rst_n)         r_vld[s] <= 1'b0;
            else if (w_free[s]) r_vld[s] <= w_vld_in;
        end

        if (s < STAGES - 1) begin : g_mid
            assign w_src[s+1] = r_mid[s];

            always_ff @(posedge clk) begin
                if (!rst_n)         r_mid[s] <= '0;
                else if (w_free[s]) r_mid[s] <= w_lvl;
            end
        end else begin : g_out
            logic [WIDTH-1:0] w_carry;
            logic [WIDTH-1:0] w_sum;
            logic             w_unused_p;

            assign w_carry    = {w_lvl.g[WIDTH-2:0], w_lvl.cin};
            assign w_sum      = w_lvl.x ^ w_carry;
            assign w_unused_p = ^w_lvl.p;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sum  <= '0;
                    r_cout <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_tag  <= '0;
                end else if (w_free[s]) begin
                    r_sum  <= w_sum;
                    r_cout <= w_lvl.g[WIDTH-1];
                    r_ovf  <= (w_lvl.a_msb == w_lvl.b_msb) && (w_sum[WIDTH-1] != w_lvl.a_msb);
                    r_tag  <= w_lvl.tag;
                end
            end
        end
    end

    assign in_ready  = w_free[0];
    assign out_valid = r_vld[STAGES-1];
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_ovf   = r_ovf;
    assign out_tag   = r_tag;

endmodule

// File: tb/tb_bk_adder_pipe.sv
// Scoreboard bench for bk_adder_pipe: stimulus pushes expected results computed with plain
// integer arithmetic; an independent monitor pops and compares on every output transfer.
module tb_bk_adder_pipe;

    localparam int W = 16;
    localparam int S = 3;
    localparam int T = 4;

    typedef logic [W+2+T-1:0] res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic [T-1:0] in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic [T-1:0] out_tag;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_out = 0;
    int   n_stall = 0;
    bit   tog_done = 1'b0;

    always #5 clk = ~clk;

    bk_adder_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(T)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_cin   (in_cin),
        .in_sub   (in_sub),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_ovf  (out_ovf),
        .out_tag  (out_tag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: true integer arithmetic, range test for signed overflow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub, input logic [T-1:0] tag);
        int   ua, ub, sa, sb, r, sr;
        logic co, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (!sub) begin
            r  = ua + ub + int'(cin);
            co = (r >= (1 << W));
            sr = sa + sb + int'(cin);
        end else begin
            r  = ua - ub - int'(cin);
            co = (r >= 0);
            sr = sa - sb - int'(cin);
        end
        ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
        return {r[W-1:0], co, ov, tag};
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [T-1:0] tag);
        logic done;
        done     = 1'b0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b, cin, sub, tag));
                done = 1'b1;
            end else begin
                n_stall++;
            end
        end
        if (!done) check("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             T'($urandom));
    endtask

    task automatic drain();
        for (int cyc = 0; cyc < 100 && (exp_q.size() != 0 || out_valid); cyc++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare every transfer; also require stalled output to stay frozen.
    initial begin
        res_t act;
        res_t held;
        logic hold;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            act = {out_sum, out_cout, out_ovf, out_tag};
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) check("hold_stable", 32'({out_valid, act}), 32'({1'b1, held}));
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) check("spurious_result", 32'(out_valid), 32'd0);
                    else check("result", 32'(act), 32'(exp_q.pop_front()));
                end
                hold = out_valid && !out_ready;
                held = act;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int           s0, o0;
        logic [W-1:0] ha, hb;
        logic [T-1:0] ht;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'({out_sum, out_cout, out_ovf, out_tag}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed cases; first one also measures latency.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 4'd3);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("latency_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("latency_arrive", 32'(out_valid), 32'd1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 4'd5);
        send(16'h1234, 16'h4321, 1'b1, 1'b0, 4'd6);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 4'd9);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 4'd12);
        in_valid = 1'b0;
        drain();

        // Back-to-back random stream with the output always ready.
        out_ready = 1'b1;
        s0 = n_stall;
        o0 = n_out;
        for (int i = 0; i < 100; i++) send_rand();
        in_valid = 1'b0;
        drain();
        check("stream_stalls", 32'(n_stall - s0), 32'd0);
        check("stream_count", 32'(n_out - o0), 32'd100);

        // Output blocked: three ops fill the pipe, the fourth must wait.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        ha = W'($urandom);
        hb = W'($urandom);
        ht = T'($urandom);
        in_a     = ha;
        in_b     = hb;
        in_cin   = 1'b1;
        in_sub   = 1'b0;
        in_tag   = ht;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("full_in_ready", 32'(in_ready), 32'd0);
        end
        check("stall_front", 32'(out_sum), 32'(exp_q[0][W+2+T-1 -: W]));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(ha, hb, 1'b1, 1'b0, ht);
        in_valid = 1'b0;
        drain();

        // Random back-pressure on the output.
        tog_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) send_rand();
                in_valid = 1'b0;
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with three ops in flight: none of them may appear afterwards.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        in_valid = 1'b0;
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_out_data", 32'({out_sum, out_cout, out_ovf, out_tag}), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        o0        = n_out;
        repeat (8) @(posedge clk);
        #1;
        check("no_ghost_results", 32'(n_out - o0), 32'd0);
        send(16'h00FF, 16'h0F0F, 1'b0, 1'b1, 4'd7);
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
